// File: rtl/corep.sv
// Shared core definitions for the branch checkpoint buffer and its controller.
package corep;

  localparam int BCB_ENTRIES = 8;

  typedef logic [$clog2(BCB_ENTRIES)-1:0] BCB_idx_t;

  // Snapshot of predictor state needed to resume after a mispredict.
  typedef struct packed {
    logic [11:0] target;
    logic [3:0]  ghist;
  } BTB_info_t;

  typedef enum logic [1:0] {
    BCS_IDLE    = 2'd0,
    BCS_RESTORE = 2'd1,
    BCS_RESP    = 2'd2
  } bcb_ctrl_state_t;

endpackage

// File: rtl/bcb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the last winner loses a tie on the next grant.
module bcb_ctrl_rr_arb2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  // 0 = req0 won last, 1 = req1 won last; resets to 1 so req0 wins the first tie.
  logic r_rr_last;

  assign o_gnt0 = i_en & i_req0 & (~i_req1 | r_rr_last);
  assign o_gnt1 = i_en & i_req1 & (~i_req0 | ~r_rr_last);

  // Remember which requester won the most recent grant.
  always_ff @(posedge i_clk) begin
    if (i_rst)       r_rr_last <= 1'b1;
    else if (o_gnt0) r_rr_last <= 1'b0;
    else if (o_gnt1) r_rr_last <= 1'b1;
  end

endmodule

// File: rtl/bcb_ctrl.sv
// Branch checkpoint buffer controller: save arbitration, liveness tracking and
// the two-cycle mispredict restore sequence.
//
// state   | meaning
// IDLE    | saves allowed; waiting for a restore request
// RESTORE | reading the checkpoint at r_idx and squashing younger entries
// RESP    | presenting the captured checkpoint for one cycle
module bcb_ctrl #(
  parameter int BCB_ENTRIES = corep::BCB_ENTRIES,
  parameter int INFO_W      = $bits(corep::BTB_info_t),
  parameter int IDX_W       = $clog2(BCB_ENTRIES)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0_valid,
  input  logic [INFO_W-1:0] req0_info,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [INFO_W-1:0] req1_info,
  output logic              req1_ready,
  output logic [IDX_W-1:0]  grant_index,
  output logic              save_valid,
  output logic [INFO_W-1:0] save_bcb_info,
  input  logic [IDX_W-1:0]  save_bcb_index,
  output logic [IDX_W-1:0]  restore_bcb_index,
  input  logic [INFO_W-1:0] restore_bcb_info,
  input  logic              restore_req_valid,
  input  logic [IDX_W-1:0]  restore_req_index,
  output logic              restore_busy,
  output logic              restore_resp_valid,
  output logic [INFO_W-1:0] restore_resp_info,
  input  logic              retire_valid,
  input  logic [IDX_W-1:0]  retire_index,
  output logic              full,
  output logic [IDX_W:0]    occupancy
);
  import corep::*;

  localparam logic [1:0] S_IDLE    = BCS_IDLE;
  localparam logic [1:0] S_RESTORE = BCS_RESTORE;
  localparam logic [1:0] S_RESP    = BCS_RESP;
  localparam logic [IDX_W:0] N_W   = (IDX_W+1)'(BCB_ENTRIES);

  logic [BCB_ENTRIES-1:0] r_valid;
  logic [BCB_ENTRIES-1:0] w_valid_nxt;
  logic [1:0]             r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [INFO_W-1:0]      r_resp_info;
  logic                   w_full;
  logic                   w_save_en;
  logic                   w_gnt0;
  logic                   w_gnt1;
  logic [IDX_W:0]         w_dist_save;
  logic [IDX_W:0]         w_occ;

  // Circular distance (a - b) mod N; the sign bit of the wide difference flags a wrap.
  function automatic logic [IDX_W:0] mod_dist(logic [IDX_W-1:0] a, logic [IDX_W-1:0] b);
    logic [IDX_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[IDX_W]) d = d + N_W;
    return d;
  endfunction

  // Full means the slot the BCB will write next is still live; loop avoids
  // out-of-range selects when N is not a power of two.
  always_comb begin
    w_full = 1'b0;
    for (int i = 0; i < BCB_ENTRIES; i++)
      if (IDX_W'(i) == save_bcb_index) w_full = r_valid[i];
  end

  assign w_save_en = ~RST & (r_state == S_IDLE) & ~restore_req_valid & ~w_full;

  bcb_ctrl_rr_arb2 u_arb (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_en   (w_save_en),
    .i_req0 (req0_valid),
    .i_req1 (req1_valid),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  assign w_dist_save = mod_dist(save_bcb_index, r_idx);

  // Next liveness: retire and squash clear first, then a granted save sets its slot.
  always_comb begin
    w_valid_nxt = r_valid;
    for (int i = 0; i < BCB_ENTRIES; i++) begin
      if (retire_valid && (IDX_W'(i) == retire_index)) w_valid_nxt[i] = 1'b0;
      if ((r_state == S_RESTORE) && (mod_dist(IDX_W'(i), r_idx) != '0) &&
          (mod_dist(IDX_W'(i), r_idx) < w_dist_save))
        w_valid_nxt[i] = 1'b0;
      if ((w_gnt0 || w_gnt1) && (IDX_W'(i) == save_bcb_index)) w_valid_nxt[i] = 1'b1;
    end
  end

  // Register per-entry liveness.
  always_ff @(posedge CLK) begin
    if (RST) r_valid <= '0;
    else     r_valid <= w_valid_nxt;
  end

  // Restore sequencer; requests arriving outside IDLE are dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_resp_info <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (restore_req_valid) begin
            r_state <= S_RESTORE;
            r_idx   <= restore_req_index;
          end
        end
        S_RESTORE: begin
          r_resp_info <= restore_bcb_info;
          r_state     <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Population count of live entries.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < BCB_ENTRIES; i++) w_occ = w_occ + (IDX_W+1)'(r_valid[i]);
  end

  assign req0_ready         = w_gnt0;
  assign req1_ready         = w_gnt1;
  assign save_valid         = w_gnt0 | w_gnt1;
  assign save_bcb_info      = w_gnt1 ? req1_info : req0_info;
  assign grant_index        = save_bcb_index;
  assign restore_bcb_index  = r_idx;
  assign restore_busy       = (r_state != S_IDLE);
  assign restore_resp_valid = (r_state == S_RESP);
  assign restore_resp_info  = r_resp_info;
  assign full               = w_full;
  assign occupancy          = w_occ;

endmodule
